// File: rtl/vaelix_key_conditioner.sv
// vaelix_key_conditioner: sync, debounce and key-check front end
// for the Sentinel gate, with failed-attempt count and lockout.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   ena           synchronous power-state enable
//   sw_raw[7:0]   raw DIP switches (async)
//   commit_raw    raw COMMIT button, active high (async)
//   key_out[7:0]  conditioned key to the gate
//   attempt_pass  1-cycle pulse, committed key == KEY
//   attempt_fail  1-cycle pulse, committed key != KEY
//   fail_cnt[3:0] consecutive failed attempts
//   lockout       high while locked out
//
// Build option: define VAELIX_LOCKOUT_EN to build the LOCKOUT
// state and timer; without it fail_cnt just saturates.

module vaelix_kc_debounce #(
  parameter int W      = 8,
  parameter int CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sync,
  output logic [W-1:0] stable
);

  localparam logic [7:0] LAST = 8'(CYCLES - 1);

  logic [W-1:0] cand;
  logic [7:0]   cnt;

  // Any change of the candidate restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand   <= '0;
      stable <= '0;
      cnt    <= '0;
    end else if (sync != cand) begin
      cand <= sync;
      cnt  <= '0;
    end else if (cand != stable) begin
      if (cnt == LAST) begin
        stable <= cand;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

module vaelix_key_conditioner #(
  parameter logic [7:0] KEY             = 8'hB6,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter int         MAX_FAILS       = 3,
  parameter int         LOCKOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] sw_raw,
  input  logic       commit_raw,
  output logic [7:0] key_out,
  output logic       attempt_pass,
  output logic       attempt_fail,
  output logic [3:0] fail_cnt,
  output logic       lockout
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range 1..255");
  end
  if (MAX_FAILS < 1 || MAX_FAILS > 15) begin : g_bad_mf
    $error("MAX_FAILS out of range 1..15");
  end
  if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 65535) begin : g_bad_lc
    $error("LOCKOUT_CYCLES out of range 1..65535");
  end

  localparam logic [3:0] MF      = 4'(MAX_FAILS);
  localparam logic [3:0] MF_LAST = 4'(MAX_FAILS - 1);

  logic [7:0] sw_s1;
  logic [7:0] sw_s2;
  logic       cm_s1;
  logic       cm_s2;
  logic [7:0] sw_stable;
  logic       commit_db;
  logic       commit_q;
  logic       attempt;
  logic       match;

  // Synchronisers and commit edge register ignore ena, so an
  // edge swallowed while disabled is never replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      cm_s1    <= 1'b0;
      cm_s2    <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      sw_s1    <= sw_raw;
      sw_s2    <= sw_s1;
      cm_s1    <= commit_raw;
      cm_s2    <= cm_s1;
      commit_q <= commit_db;
    end
  end

  vaelix_kc_debounce #(
    .W      (8),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_db_sw (
    .clk    (clk),
    .rst_n  (rst_n),
    .sync   (sw_s2),
    .stable (sw_stable)
  );

  vaelix_kc_debounce #(
    .W      (1),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_db_cm (
    .clk    (clk),
    .rst_n  (rst_n),
    .sync   (cm_s2),
    .stable (commit_db)
  );

  assign attempt = commit_db & ~commit_q;
  assign match   = (sw_stable == KEY);

`ifdef VAELIX_LOCKOUT_EN

  localparam logic [15:0] LC_LAST = 16'(LOCKOUT_CYCLES - 1);

  typedef enum logic {
    ARMED   = 1'b0,
    LOCKOUT = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARMED;
      timer        <= '0;
      fail_cnt     <= '0;
      attempt_pass <= 1'b0;
      attempt_fail <= 1'b0;
    end else begin
      attempt_pass <= 1'b0;
      attempt_fail <= 1'b0;
      if (ena) begin
        unique case (state)
          ARMED: begin
            if (attempt && match) begin
              attempt_pass <= 1'b1;
              fail_cnt     <= '0;
            end else if (attempt) begin
              attempt_fail <= 1'b1;
              if (fail_cnt == MF_LAST) begin
                fail_cnt <= MF;
                timer    <= LC_LAST;
                state    <= LOCKOUT;
              end else begin
                fail_cnt <= fail_cnt + 4'd1;
              end
            end
          end
          LOCKOUT: begin
            if (timer == '0) begin
              state    <= ARMED;
              fail_cnt <= '0;
            end else begin
              timer <= timer - 16'd1;
            end
          end
          default: state <= ARMED;
        endcase
      end
    end
  end

  assign lockout = (state == LOCKOUT);
  assign key_out = (ena && state == ARMED) ? sw_stable : 8'h00;

`else

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt     <= '0;
      attempt_pass <= 1'b0;
      attempt_fail <= 1'b0;
    end else begin
      attempt_pass <= 1'b0;
      attempt_fail <= 1'b0;
      if (ena && attempt) begin
        unique case (1'b1)
          match: begin
            attempt_pass <= 1'b1;
            fail_cnt     <= '0;
          end
          default: begin
            attempt_fail <= 1'b1;
            if (fail_cnt != MF) begin
              fail_cnt <= fail_cnt + 4'd1;
            end
          end
        endcase
      end
    end
  end

  assign lockout = 1'b0;
  assign key_out = ena ? sw_stable : 8'h00;

`endif

endmodule

// File: tb/tb_vaelix_key_conditioner.sv
// tb_vaelix_key_conditioner: directed bench with a pulse scoreboard.
// DEBOUNCE_CYCLES=4, MAX_FAILS=3, LOCKOUT_CYCLES=32.

module tb_vaelix_key_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] sw_raw = 8'h00;
  logic       commit_raw = 1'b0;
  logic [7:0] key_out;
  logic       attempt_pass;
  logic       attempt_fail;
  logic [3:0] fail_cnt;
  logic       lockout;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       pass;
    logic [3:0] cnt;
    logic       lock;
  } exp_t;

  exp_t exp_q[$];

  vaelix_key_conditioner #(
    .KEY             (8'hB6),
    .DEBOUNCE_CYCLES (4),
    .MAX_FAILS       (3),
    .LOCKOUT_CYCLES  (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .sw_raw       (sw_raw),
    .commit_raw   (commit_raw),
    .key_out      (key_out),
    .attempt_pass (attempt_pass),
    .attempt_fail (attempt_fail),
    .fail_cnt     (fail_cnt),
    .lockout      (lockout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (attempt_pass || attempt_fail)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse",
            {14'd0, attempt_pass, attempt_fail}, 16'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_pass", {15'd0, attempt_pass}, {15'd0, e.pass});
        chk("pulse_fail", {15'd0, attempt_fail}, {15'd0, ~e.pass});
        chk("pulse_cnt", {12'd0, fail_cnt}, {12'd0, e.cnt});
        chk("pulse_lock", {15'd0, lockout}, {15'd0, e.lock});
      end
    end
  end

  // Full press/release; afterwards every expectation must be consumed.
  task automatic commit(input logic p, input logic [3:0] c,
                        input logic l);
    exp_q.push_back('{pass: p, cnt: c, lock: l});
    commit_raw = 1'b1;
    tick(10);
    commit_raw = 1'b0;
    tick(10);
    chk("pulse_seen", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic set_sw(input logic [7:0] v);
    sw_raw = v;
    tick(8);
    chk("key_settle", {8'd0, key_out}, {8'd0, v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lock_cyc;
    int key_bad;

    // reset values
    #3;
    chk("rst_key", {8'd0, key_out}, 16'h0000);
    chk("rst_pass", {15'd0, attempt_pass}, 16'd0);
    chk("rst_fail", {15'd0, attempt_fail}, 16'd0);
    chk("rst_cnt", {12'd0, fail_cnt}, 16'd0);
    chk("rst_lock", {15'd0, lockout}, 16'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // debounce latency: stable 6 edges after first sample
    sw_raw = 8'hB6;
    tick(6);
    chk("db_early", {8'd0, key_out}, 16'h0000);
    tick(1);
    chk("db_latency", {8'd0, key_out}, 16'h00B6);

    // 3-cycle glitch must be filtered
    sw_raw = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("glitch_hold", {8'd0, key_out}, 16'h00B6);
      if (i == 2) sw_raw = 8'hB6;
    end

    // pass: exact pulse timing, one pulse per press
    exp_q.push_back('{pass: 1'b1, cnt: 4'd0, lock: 1'b0});
    commit_raw = 1'b1;
    tick(7);
    chk("pass_early", {15'd0, attempt_pass}, 16'd0);
    tick(1);
    chk("pass_latency", {15'd0, attempt_pass}, 16'd1);
    tick(1);
    chk("pass_width", {15'd0, attempt_pass}, 16'd0);
    tick(7);
    commit_raw = 1'b0;
    tick(10);
    chk("pass_seen", 16'(exp_q.size()), 16'd0);
    commit(1'b1, 4'd0, 1'b0);

    // two fails then a pass clears the count
    set_sw(8'h12);
    commit(1'b0, 4'd1, 1'b0);
    commit(1'b0, 4'd2, 1'b0);
    set_sw(8'hB6);
    commit(1'b1, 4'd0, 1'b0);
    chk("failrst_lock", {15'd0, lockout}, 16'd0);

    // ena gating: held press across ena low/high never pulses
    ena = 1'b0;
    tick(2);
    chk("ena_key0", {8'd0, key_out}, 16'h0000);
    commit_raw = 1'b1;
    tick(10);
    chk("ena_key0_held", {8'd0, key_out}, 16'h0000);
    ena = 1'b1;
    tick(10);
    chk("ena_key_back", {8'd0, key_out}, 16'h00B6);
    commit_raw = 1'b0;
    tick(10);
    chk("ena_cnt", {12'd0, fail_cnt}, 16'd0);

`ifdef VAELIX_LOCKOUT_EN
    // lockout entry, duration, discarded commit, exit
    set_sw(8'h12);
    commit(1'b0, 4'd1, 1'b0);
    commit(1'b0, 4'd2, 1'b0);
    exp_q.push_back('{pass: 1'b0, cnt: 4'd3, lock: 1'b1});
    commit_raw = 1'b1;
    tick(8);
    chk("lock_rise", {15'd0, lockout}, 16'd1);
    chk("lock_key0", {8'd0, key_out}, 16'h0000);
    commit_raw = 1'b0;
    lock_cyc = 0;
    key_bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (lockout) begin
        lock_cyc++;
        if (key_out != 8'h00) key_bad++;
      end
      if (i == 8) commit_raw = 1'b1;
      if (i == 18) commit_raw = 1'b0;
      tick(1);
    end
    chk("lock_cycles", 16'(lock_cyc), 16'd32);
    chk("lock_key_zero", 16'(key_bad), 16'd0);
    chk("unlock_cnt", {12'd0, fail_cnt}, 16'd0);
    chk("unlock_key", {8'd0, key_out}, 16'h0012);
    chk("lock_queue", 16'(exp_q.size()), 16'd0);

    // reset at lockout cycle 10
    commit(1'b0, 4'd1, 1'b0);
    commit(1'b0, 4'd2, 1'b0);
    exp_q.push_back('{pass: 1'b0, cnt: 4'd3, lock: 1'b1});
    commit_raw = 1'b1;
    tick(8);
    commit_raw = 1'b0;
    tick(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_key", {8'd0, key_out}, 16'h0000);
    chk("arst_pass", {15'd0, attempt_pass}, 16'd0);
    chk("arst_fail", {15'd0, attempt_fail}, 16'd0);
    chk("arst_cnt", {12'd0, fail_cnt}, 16'd0);
    chk("arst_lock", {15'd0, lockout}, 16'd0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("post_rst_lock", {15'd0, lockout}, 16'd0);
    chk("post_rst_key", {8'd0, key_out}, 16'h0012);
    commit(1'b0, 4'd1, 1'b0);
`else
    // no lockout: count saturates, passes still accepted
    set_sw(8'h12);
    commit(1'b0, 4'd1, 1'b0);
    commit(1'b0, 4'd2, 1'b0);
    commit(1'b0, 4'd3, 1'b0);
    commit(1'b0, 4'd3, 1'b0);
    commit(1'b0, 4'd3, 1'b0);
    chk("sat_cnt", {12'd0, fail_cnt}, 16'd3);
    chk("sat_lock", {15'd0, lockout}, 16'd0);
    chk("sat_key", {8'd0, key_out}, 16'h0012);
    set_sw(8'hB6);
    commit(1'b1, 4'd0, 1'b0);
    chk("sat_clear", {12'd0, fail_cnt}, 16'd0);
`endif

    tick(5);
    chk("queue_drain", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
